rv_mem_arbiter: RTL and testbench
=================================

Name: rv_mem_arbiter

Overview:
- Two-master, one-slave arbiter on the core data-memory request/rvalid interface.
- Master 0 is instruction fetch; master 1 is the load/store unit.
- The single slave port feeds the SRAM driver directly.
- It serialises the two masters onto the single SRAM, alternates between them round-robin, and returns an error response if the slave never answers.

Parameters:
- TIMEOUT, 64: maximum number of cycles req_o may stay high without rvalid_i before a forced error completion. Legal range is 2 to 65535.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- m0_req_i, m1_req_i  in  1  request. Held high with stable attributes until that master's rvalid.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_be_i, m1_be_i  in  XLEN/8  byte enables.
- m0_addr_i, m1_addr_i  in  XLEN  byte address.
- m0_wdata_i, m1_wdata_i  in  XLEN  write data.
- m0_rvalid_o, m1_rvalid_o  out  1  one-cycle completion pulse.
- m0_rdata_o, m1_rdata_o  out  XLEN  read data, valid only with rvalid.
- m0_err_o, m1_err_o  out  1  pulses together with rvalid on a timeout completion.
- req_o  out  1  slave request.
- we_o  out  1  slave write enable.
- be_o  out  XLEN/8  slave byte enables.
- addr_o  out  XLEN  slave address.
- wdata_o  out  XLEN  slave write data.
- rvalid_i  in  1  slave completion pulse.
- rdata_i  in  XLEN  slave read data.

Behaviour:
- Reset: all outputs are synchronously cleared on the next clk_i edge with rst_i high.
  - This includes req_o, we_o, be_o, addr_o, wdata_o, both rvalid, both rdata and both err outputs.
  - State goes to ARB_IDLE, the timeout counter to 0, last_grant to 1 (so master 0 wins the first tie).
- Reset mid-transaction: the transaction is abandoned and no rvalid is sent to any master. The SRAM driver shares this reset.
- States: ARB_IDLE, ARB_BUSY.
- ARB_IDLE:
  - If either req is high, pick a winner and register the winner's we/be/addr/wdata into the slave-side registers.
  - Store the winner in grant and last_grant, then go to ARB_BUSY.
  - Tie break: the master not equal to last_grant wins. A single requester always wins.
- ARB_BUSY:
  - req_o = 1 while not completing. req_o is forced to 0 combinationally in the cycle rvalid_i is high, matching the driver's handshake.
  - Slave attribute outputs hold their registered values for the whole transaction.
  - The counter increments each cycle.
- Normal completion, when rvalid_i = 1:
  - In the same cycle, assert m{grant}_rvalid_o = 1 and m{grant}_rdata_o = rdata_i, combinationally routed.
  - Next state is ARB_IDLE.
  - The counter clears.
- Timeout completion, when the counter reaches TIMEOUT - 1 and rvalid_i = 0:
  - Drive m{grant}_rvalid_o = 1, m{grant}_err_o = 1 and m{grant}_rdata_o = 32'hDEAD_BEEF.
  - Drop req_o in that cycle and go to ARB_IDLE.
  - A late rvalid_i arriving in ARB_IDLE is ignored.
- Latency:
  - Master req to req_o high: 1 cycle.
  - Slave rvalid_i to master rvalid: 0 cycles.
  - There is exactly one ARB_IDLE cycle between transactions, so a continuous requester is served at most every (slave latency + 2) cycles.
- Ungranted master: rvalid, err and rdata outputs stay at 0. Its request stays pending and is not sampled until ARB_IDLE.
- Master requests are ignored while in ARB_BUSY, including the completion cycle.
- rvalid_i arriving in ARB_IDLE, whether spurious or late, is dropped.
- Widths: the counter is $clog2(TIMEOUT+1) bits, saturating-safe because it clears on completion. addr, be and wdata pass through unmodified, with no alignment checks.

Decomposition:
- rv_pkg gains:
  - typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;
  - localparam logic [XLEN-1:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;
  - a packed struct mem_req_t {we, be, addr, wdata}, reused by the SRAM test top.
- XLEN comes from rv_pkg.
- One sub-module, rv_rr_pick2: combinational two-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: gnt_valid, gnt_idx.
- The FSM, registers and timeout counter stay in rv_mem_arbiter.

Test Plan:
- Single master 1 write: we=1, be=1111, addr=12, wdata=12345678, slave rvalid 3 cycles after req_o.
  - req_o rises 1 cycle after m1_req_i.
  - Slave sees addr=12, wdata=12345678.
  - m1_rvalid_o pulses for 1 cycle, m0 outputs stay 0.
- Simultaneous requests after reset: m0 read addr 0, m1 read addr 12.
  - m0 is served first; m1 is served next, after one ARB_IDLE cycle.
  - With both still requesting, the third grant goes to m0 (strict alternation).
- Read data routing: slave returns rdata=00004321 for the m1 read.
  - m1_rdata_o=00004321 in the rvalid cycle; m0_rdata_o=0.
- Timeout: TIMEOUT=8, slave never asserts rvalid.
  - On cycle 8 of BUSY: m0_rvalid_o=1, m0_err_o=1, m0_rdata_o=DEADBEEF, req_o=0.
  - A late rvalid_i 2 cycles later produces no master rvalid.
- Reset mid-transaction: assert rst_i on the 2nd BUSY cycle.
  - Next edge: req_o=0 and all outputs 0.
  - Master 0 wins the next tie.
- Byte-enable pass-through: m0 write be=0011, wdata=00004321.
  - be_o=0011 and wdata_o=00004321, stable throughout BUSY.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared core types for the memory subsystem: data width, arbiter state
// encoding and the slave-side request bundle used by the arbiter and the SRAM test top.
package rv_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam logic [XLEN-1:0] ARB_ERR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic              we;
        logic [XLEN/8-1:0] be;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
    } mem_req_t;

endpackage

// File: rtl/rv_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// on a tie the master that was not granted last time wins.
module rv_rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Winner selection from the current request pair and the previous grant.
    always_comb begin
        gnt_valid = |req;
        case (req)
            2'b01:   gnt_idx = 1'b0;
            2'b10:   gnt_idx = 1'b1;
            2'b11:   gnt_idx = ~last;
            default: gnt_idx = 1'b0;
        endcase
    end

endmodule

// File: rtl/rv_mem_arbiter.sv
// Two-master (fetch, load/store) to one-SRAM arbiter with round-robin grant
// and a forced error completion when the slave does not answer in time.
module rv_mem_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [XLEN/8-1:0] m0_be_i,
    input  logic [XLEN-1:0]   m0_addr_i,
    input  logic [XLEN-1:0]   m0_wdata_i,
    output logic              m0_rvalid_o,
    output logic [XLEN-1:0]   m0_rdata_o,
    output logic              m0_err_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [XLEN/8-1:0] m1_be_i,
    input  logic [XLEN-1:0]   m1_addr_i,
    input  logic [XLEN-1:0]   m1_wdata_i,
    output logic              m1_rvalid_o,
    output logic [XLEN-1:0]   m1_rdata_o,
    output logic              m1_err_o,
    output logic              req_o,
    output logic              we_o,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   addr_o,
    output logic [XLEN-1:0]   wdata_o,
    input  logic              rvalid_i,
    input  logic [XLEN-1:0]   rdata_i
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t       state_r;
    logic             grant_r;
    logic             last_grant_r;
    logic [CNT_W-1:0] cnt_r;
    mem_req_t         slv_req_r;

    mem_req_t         m0_req_s;
    mem_req_t         m1_req_s;
    mem_req_t         win_req_s;
    logic             gnt_valid_s;
    logic             gnt_idx_s;
    logic             busy_s;
    logic             done_ok_s;
    logic             done_to_s;
    logic             done_s;

    rv_rr_pick2 u_pick (
        .req       ({m1_req_i, m0_req_i}),
        .last      (last_grant_r),
        .gnt_valid (gnt_valid_s),
        .gnt_idx   (gnt_idx_s)
    );

    // Bundle each master's attributes and select the winner's bundle.
    always_comb begin
        m0_req_s.we    = m0_we_i;
        m0_req_s.be    = m0_be_i;
        m0_req_s.addr  = m0_addr_i;
        m0_req_s.wdata = m0_wdata_i;
        m1_req_s.we    = m1_we_i;
        m1_req_s.be    = m1_be_i;
        m1_req_s.addr  = m1_addr_i;
        m1_req_s.wdata = m1_wdata_i;
        if (gnt_idx_s) begin
            win_req_s = m1_req_s;
        end else begin
            win_req_s = m0_req_s;
        end
    end

    // Completion detection; a slave answer in the last allowed cycle beats the timeout.
    always_comb begin
        busy_s    = (state_r == ARB_BUSY);
        done_ok_s = busy_s && rvalid_i;
        done_to_s = busy_s && !rvalid_i && (cnt_r == CNT_LAST);
        done_s    = done_ok_s || done_to_s;
    end

    // Arbiter FSM, grant bookkeeping, captured slave request and timeout counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r      <= ARB_IDLE;
            grant_r      <= 1'b0;
            last_grant_r <= 1'b1;
            cnt_r        <= '0;
            slv_req_r    <= '0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    cnt_r <= '0;
                    if (gnt_valid_s) begin
                        state_r      <= ARB_BUSY;
                        grant_r      <= gnt_idx_s;
                        last_grant_r <= gnt_idx_s;
                        slv_req_r    <= win_req_s;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_BUSY: begin
                    if (done_s) begin
                        state_r <= ARB_IDLE;
                        cnt_r   <= '0;
                    end else begin
                        state_r <= ARB_BUSY;
                        cnt_r   <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r <= ARB_IDLE;
                    cnt_r   <= '0;
                end
            endcase
        end
    end

    // Slave-side drive: req drops in the completing cycle to match the driver handshake.
    always_comb begin
        req_o   = busy_s && !done_s;
        we_o    = slv_req_r.we;
        be_o    = slv_req_r.be;
        addr_o  = slv_req_r.addr;
        wdata_o = slv_req_r.wdata;
    end

    // Completion routing to the granted master only; the other master sees zeros.
    always_comb begin
        m0_rvalid_o = 1'b0;
        m0_err_o    = 1'b0;
        m0_rdata_o  = '0;
        m1_rvalid_o = 1'b0;
        m1_err_o    = 1'b0;
        m1_rdata_o  = '0;
        if (done_s && grant_r) begin
            m1_rvalid_o = 1'b1;
            m1_err_o    = done_to_s;
            m1_rdata_o  = done_ok_s ? rdata_i : ARB_ERR_RDATA;
        end else if (done_s) begin
            m0_rvalid_o = 1'b1;
            m0_err_o    = done_to_s;
            m0_rdata_o  = done_ok_s ? rdata_i : ARB_ERR_RDATA;
        end else begin
            m0_rvalid_o = 1'b0;
            m1_rvalid_o = 1'b0;
        end
    end

endmodule

// File: tb/tb_rv_mem_arbiter.sv
// Self-checking bench for rv_mem_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level model of the arbitration rules.
module tb_rv_mem_arbiter;
    import rv_pkg::*;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              m0_req_i, m1_req_i, m0_we_i, m1_we_i;
    logic [XLEN/8-1:0] m0_be_i, m1_be_i;
    logic [XLEN-1:0]   m0_addr_i, m1_addr_i, m0_wdata_i, m1_wdata_i;
    logic              m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o;
    logic [XLEN-1:0]   m0_rdata_o, m1_rdata_o;
    logic              req_o, we_o, rvalid_i;
    logic [XLEN/8-1:0] be_o;
    logic [XLEN-1:0]   addr_o, wdata_o, rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_mem_arbiter #(.TIMEOUT(8)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_be_i(m0_be_i), .m0_addr_i(m0_addr_i),
        .m0_wdata_i(m0_wdata_i), .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o), .m0_err_o(m0_err_o),
        .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i), .m1_addr_i(m1_addr_i),
        .m1_wdata_i(m1_wdata_i), .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o), .m1_err_o(m1_err_o),
        .req_o(req_o), .we_o(we_o), .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o),
        .rvalid_i(rvalid_i), .rdata_i(rdata_i)
    );

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive_edge();
        rst_i = 1'b1; rvalid_i = 1'b0; rdata_i = '0;
        m0_req_i = 1'b0; m0_we_i = 1'b0; m0_be_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 1'b0; m1_we_i = 1'b0; m1_be_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
        drive_edge();
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst_i = 1'b1; m0_req_i = 1'b1; m1_req_i = 1'b1; rvalid_i = 1'b1; rdata_i = 32'h1111_2222;
        drive_edge();
        drive_edge();
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL reset_req got=%0h exp=0", req_o); end
        n_cmp++; if ({we_o, be_o, addr_o, wdata_o} !== '0) begin n_err++; $display("FAIL reset_slave_attr got=%0h exp=0", {we_o, be_o, addr_o, wdata_o}); end
        n_cmp++; if ({m0_rvalid_o, m0_err_o, m0_rdata_o} !== '0) begin n_err++; $display("FAIL reset_m0_out got=%0h exp=0", {m0_rvalid_o, m0_err_o, m0_rdata_o}); end
        n_cmp++; if ({m1_rvalid_o, m1_err_o, m1_rdata_o} !== '0) begin n_err++; $display("FAIL reset_m1_out got=%0h exp=0", {m1_rvalid_o, m1_err_o, m1_rdata_o}); end
        drive_edge();
        rst_i = 1'b0; m0_req_i = 1'b0; m1_req_i = 1'b0;
        @(negedge clk);
        n_cmp++; if ({m0_rvalid_o, m1_rvalid_o} !== 2'b00) begin n_err++; $display("FAIL spurious_rvalid got=%0b exp=00", {m1_rvalid_o, m0_rvalid_o}); end
        rvalid_i = 1'b0;
    endtask

    task automatic test_single_write();
        do_reset();
        m1_req_i = 1'b1; m1_we_i = 1'b1; m1_be_i = 4'b1111; m1_addr_i = 32'd12; m1_wdata_i = 32'h1234_5678;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL sw_req_early got=%0h exp=0", req_o); end
        for (int k = 1; k <= 4; k++) begin
            drive_edge();
            rvalid_i = (k == 4); rdata_i = 32'h0;
            @(negedge clk);
            n_cmp++; if (req_o !== (k != 4)) begin n_err++; $display("FAIL sw_req_c%0d got=%0h exp=%0h", k, req_o, k != 4); end
            n_cmp++; if ({we_o, be_o, addr_o, wdata_o} !== {1'b1, 4'b1111, 32'd12, 32'h1234_5678}) begin
                n_err++; $display("FAIL sw_attr_c%0d got=%0h/%0h/%0h/%0h exp=1/f/c/12345678", k, we_o, be_o, addr_o, wdata_o); end
            n_cmp++; if (m1_rvalid_o !== (k == 4)) begin n_err++; $display("FAIL sw_m1_rvalid_c%0d got=%0h exp=%0h", k, m1_rvalid_o, k == 4); end
            n_cmp++; if ({m0_rvalid_o, m0_err_o, m0_rdata_o, m1_err_o} !== '0) begin n_err++; $display("FAIL sw_m0_quiet_c%0d got=%0h exp=0", k, {m0_rvalid_o, m0_err_o, m0_rdata_o, m1_err_o}); end
        end
        drive_edge();
        m1_req_i = 1'b0; rvalid_i = 1'b0;
        @(negedge clk);
        n_cmp++; if ({m1_rvalid_o, req_o} !== 2'b00) begin n_err++; $display("FAIL sw_after got=%0b exp=00", {m1_rvalid_o, req_o}); end
    endtask

    task automatic test_tie_alternation();
        do_reset();
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'd0;
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'd12;
        drive_edge();
        rvalid_i = 1'b1; rdata_i = 32'h0000_AAAA;
        @(negedge clk);
        n_cmp++; if (addr_o !== 32'd0) begin n_err++; $display("FAIL tie_first_addr got=%0h exp=0", addr_o); end
        n_cmp++; if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o} !== {2'b10, 32'h0000_AAAA}) begin
            n_err++; $display("FAIL tie_first_resp got=%0b%0b/%0h exp=10/aaaa", m0_rvalid_o, m1_rvalid_o, m0_rdata_o); end
        drive_edge();
        rvalid_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL tie_gap1 got=%0h exp=0", req_o); end
        drive_edge();
        rvalid_i = 1'b1; rdata_i = 32'h0000_4321;
        @(negedge clk);
        n_cmp++; if (addr_o !== 32'd12) begin n_err++; $display("FAIL tie_second_addr got=%0h exp=c", addr_o); end
        n_cmp++; if ({m1_rvalid_o, m1_rdata_o} !== {1'b1, 32'h0000_4321}) begin n_err++; $display("FAIL rd_route_m1 got=%0h/%0h exp=1/4321", m1_rvalid_o, m1_rdata_o); end
        n_cmp++; if ({m0_rvalid_o, m0_rdata_o} !== '0) begin n_err++; $display("FAIL rd_route_m0 got=%0h/%0h exp=0/0", m0_rvalid_o, m0_rdata_o); end
        drive_edge();
        rvalid_i = 1'b0;
        @(negedge clk);
        n_cmp++; if (req_o !== 1'b0) begin n_err++; $display("FAIL tie_gap2 got=%0h exp=0", req_o); end
        drive_edge();
        rvalid_i = 1'b1; rdata_i = 32'h0;
        @(negedge clk);
        n_cmp++; if ({addr_o, m0_rvalid_o} !== {32'd0, 1'b1}) begin n_err++; $display("FAIL tie_third got=%0h/%0h exp=0/1", addr_o, m0_rvalid_o); end
        drive_edge();
        m0_req_i = 1'b0; m1_req_i = 1'b0; rvalid_i = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h44;
        for (int k = 1; k <= 8; k++) begin
            drive_edge();
            rdata_i = 32'h5555_5555;
            @(negedge clk);
            n_cmp++; if ({req_o, m0_rvalid_o, m0_err_o} !== ((k == 8) ? 3'b011 : 3'b100)) begin
                n_err++; $display("FAIL to_c%0d req/rv/err got=%0b%0b%0b exp=%0s", k, req_o, m0_rvalid_o, m0_err_o, (k == 8) ? "011" : "100"); end
        end
        n_cmp++; if (m0_rdata_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL to_rdata got=%0h exp=deadbeef", m0_rdata_o); end
        n_cmp++; if ({m1_rvalid_o, m1_err_o} !== 2'b00) begin n_err++; $display("FAIL to_m1_quiet got=%0b exp=00", {m1_rvalid_o, m1_err_o}); end
        drive_edge();
        m0_req_i = 1'b0;
        drive_edge();
        rvalid_i = 1'b1;
        @(negedge clk);
        n_cmp++; if ({m0_rvalid_o, m1_rvalid_o, req_o} !== 3'b000) begin n_err++; $display("FAIL late_rvalid got=%0b exp=000", {m0_rvalid_o, m1_rvalid_o, req_o}); end
        drive_edge();
        rvalid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_be_i = 4'hF; m0_addr_i = 32'h40; m0_wdata_i = 32'hCAFE_F00D;
        drive_edge();
        drive_edge();
        rst_i = 1'b1;
        drive_edge();
        rst_i = 1'b0; m0_req_i = 1'b0; rvalid_i = 1'b1; rdata_i = 32'h7777;
        @(negedge clk);
        n_cmp++; if ({req_o, we_o, be_o, addr_o, wdata_o} !== '0) begin n_err++; $display("FAIL rmid_slave got=%0h exp=0", {req_o, we_o, be_o, addr_o, wdata_o}); end
        n_cmp++; if ({m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o} !== 4'b0) begin n_err++; $display("FAIL rmid_no_rvalid got=%0b exp=0000", {m0_rvalid_o, m1_rvalid_o, m0_err_o, m1_err_o}); end
        drive_edge();
        rvalid_i = 1'b0;
        m0_req_i = 1'b1; m0_we_i = 1'b0; m0_addr_i = 32'h100;
        m1_req_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h200;
        drive_edge();
        rvalid_i = 1'b1;
        @(negedge clk);
        n_cmp++; if ({addr_o, m0_rvalid_o} !== {32'h100, 1'b1}) begin n_err++; $display("FAIL rmid_tie got=%0h/%0h exp=100/1", addr_o, m0_rvalid_o); end
        drive_edge();
        m0_req_i = 1'b0; m1_req_i = 1'b0; rvalid_i = 1'b0;
        drive_edge();
    endtask

    task automatic test_be_passthrough();
        do_reset();
        m0_req_i = 1'b1; m0_we_i = 1'b1; m0_be_i = 4'b0011; m0_addr_i = 32'h20; m0_wdata_i = 32'h0000_4321;
        for (int k = 1; k <= 4; k++) begin
            drive_edge();
            rvalid_i = (k == 4);
            @(negedge clk);
            n_cmp++; if ({we_o, be_o, wdata_o} !== {1'b1, 4'b0011, 32'h0000_4321}) begin
                n_err++; $display("FAIL be_c%0d got=%0h/%0h/%0h exp=1/3/4321", k, we_o, be_o, wdata_o); end
        end
        n_cmp++; if (m0_rvalid_o !== 1'b1) begin n_err++; $display("FAIL be_done got=%0h exp=1", m0_rvalid_o); end
        drive_edge();
        m0_req_i = 1'b0; rvalid_i = 1'b0;
    endtask

    // Randomized traffic: the model tracks pending masters, the current owner and the
    // slave latency it chose, then predicts every output from the arbitration rules.
    task automatic test_random();
        bit              pend [2];
        logic            we_a [2];
        logic [3:0]      be_a [2];
        logic [31:0]     addr_a [2];
        logic [31:0]     wd_a [2];
        bit              active, start_next, done_ok, done_to;
        int              owner, next_owner, k, lat, last;
        logic [31:0]     rd;
        do_reset();
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin we_a[i] = 1'b0; be_a[i] = '0; addr_a[i] = '0; wd_a[i] = '0; end
        active = 1'b0; start_next = 1'b0; owner = 0; next_owner = 0; k = 0; lat = 0; last = 1;
        for (int c = 0; c < 3000; c++) begin
            drive_edge();
            if (start_next) begin
                active = 1'b1; owner = next_owner; k = 0; lat = $urandom_range(0, 9); last = owner;
            end
            start_next = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (!pend[i] && ($urandom_range(0, 2) == 0)) begin
                    pend[i] = 1'b1; we_a[i] = 1'($urandom_range(0, 1)); be_a[i] = 4'($urandom);
                    addr_a[i] = $urandom; wd_a[i] = $urandom;
                end
            end
            m0_req_i = pend[0]; m0_we_i = we_a[0]; m0_be_i = be_a[0]; m0_addr_i = addr_a[0]; m0_wdata_i = wd_a[0];
            m1_req_i = pend[1]; m1_we_i = we_a[1]; m1_be_i = be_a[1]; m1_addr_i = addr_a[1]; m1_wdata_i = wd_a[1];
            rd = $urandom; rdata_i = rd;
            done_ok = 1'b0; done_to = 1'b0;
            if (active) begin
                k++;
                done_ok = (k == lat + 1);
                done_to = !done_ok && (k == 8);
                rvalid_i = done_ok;
            end else begin
                rvalid_i = ($urandom_range(0, 3) == 0);
            end
            @(negedge clk);
            n_cmp++; if (req_o !== (active && !done_ok && !done_to)) begin
                n_err++; $display("FAIL rnd_req cyc=%0d got=%0h exp=%0h", c, req_o, active && !done_ok && !done_to); end
            if (active) begin
                n_cmp++; if ({we_o, be_o, addr_o, wdata_o} !== {we_a[owner], be_a[owner], addr_a[owner], wd_a[owner]}) begin
                    n_err++; $display("FAIL rnd_attr cyc=%0d got=%0h/%0h/%0h exp=%0h/%0h/%0h (m%0d)", c, be_o, addr_o, wdata_o, be_a[owner], addr_a[owner], wd_a[owner], owner); end
            end
            for (int i = 0; i < 2; i++) begin
                logic        g_rv, g_err, e_rv, e_err;
                logic [31:0] g_rd, e_rd;
                g_rv  = (i == 1) ? m1_rvalid_o : m0_rvalid_o;
                g_err = (i == 1) ? m1_err_o : m0_err_o;
                g_rd  = (i == 1) ? m1_rdata_o : m0_rdata_o;
                e_rv  = active && (done_ok || done_to) && (owner == i);
                e_err = e_rv && done_to;
                e_rd  = !e_rv ? 32'h0 : (done_ok ? rd : 32'hDEAD_BEEF);
                n_cmp++; if ({g_rv, g_err, g_rd} !== {e_rv, e_err, e_rd}) begin
                    n_err++; $display("FAIL rnd_m%0d_resp cyc=%0d got=%0b/%0b/%0h exp=%0b/%0b/%0h", i, c, g_rv, g_err, g_rd, e_rv, e_err, e_rd); end
            end
            if (active) begin
                if (done_ok || done_to) begin
                    pend[owner] = 1'b0; active = 1'b0;
                end
            end else if (pend[0] || pend[1]) begin
                start_next = 1'b1;
                next_owner = (pend[0] && pend[1]) ? (1 - last) : (pend[1] ? 1 : 0);
            end
        end
        drive_edge();
        m0_req_i = 1'b0; m1_req_i = 1'b0; rvalid_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; rvalid_i = 1'b0; rdata_i = '0;
        m0_req_i = 1'b0; m0_we_i = 1'b0; m0_be_i = '0; m0_addr_i = '0; m0_wdata_i = '0;
        m1_req_i = 1'b0; m1_we_i = 1'b0; m1_be_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
        test_reset();
        test_single_write();
        test_tie_alternation();
        test_timeout();
        test_reset_mid();
        test_be_passthrough();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
